// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle for serial_adder_seq.
// in_sub is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder built around one hard 1-bit adder cell.
// Define SERIAL_ADDER_SUB_EN to add the in_sub (A-B) operation.

// Behavioural stand-in for the hard full-adder primitive.
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sumout,
    output logic cout
);
    assign sumout = a ^ b ^ cin;
    assign cout   = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one operand bit per cycle through the adder cell
// DONE  | result held on out_sum/out_cout until out_ready
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_reg;
    logic [WIDTH-1:0] b_load;
    logic             carry, carry_load;
    logic [CW-1:0]    cnt;
    logic             add_sum, add_cout;
    logic             in_ready_c, accept;

    adder u_adder (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (carry),
        .sumout (add_sum),
        .cout   (add_cout)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // A-B computed as A + ~B + 1; in_cin has no meaning for subtract.
    assign b_load     = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign carry_load = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    assign b_load     = bus.in_b;
    assign carry_load = bus.in_cin;
`endif

    assign accept = in_ready_c & bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= bus.in_a;
            b_sh  <= b_load;
            s_reg <= '0;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            // Sum bits enter at the MSB so bit 0 lands at index 0 after WIDTH shifts.
            s_reg <= {add_sum, s_reg[WIDTH-1:1]};
            carry <= add_cout;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = s_reg;
    assign bus.out_cout  = carry;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq against an arithmetic reference model.
// Build with SERIAL_ADDER_SUB_EN defined to also cover subtraction.
module tb_serial_adder_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        int unsigned s;
        logic [W:0]  r;
        if (sub) begin
            s = (int'(a) - int'(b)) & ((1 << W) - 1);
            r = {(a >= b), s[W-1:0]};
        end else begin
            s = int'(a) + int'(b) + int'(cin);
            r = s[W:0];
        end
        return r;
    endfunction

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.in_sub = sub;
`endif
    endtask

    // Issues one op and returns the result; to=1 if a bounded wait expired.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output logic [W-1:0] s, output logic co,
                          output bit to);
        int k;
        to = 1'b0;
        s  = '0;
        co = 1'b0;
        k  = 0;
        while (!bus.in_ready && k < 40) begin
            @(posedge clk); #1; k++;
        end
        if (!bus.in_ready) begin
            to = 1'b1;
            return;
        end
        drive_op(a, b, cin, sub);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
        if (!bus.out_valid) begin
            to = 1'b1;
            return;
        end
        s  = bus.out_sum;
        co = bus.out_cout;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_sum !== '0 || bus.out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=00 cout=0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout);
        end
    endtask

    task automatic test_latency;
        logic [W:0] exp;
        exp = model(8'h5A, 8'h33, 1'b0, 1'b0);
        drive_op(8'h5A, 8'h33, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== (k == W)) begin
                errors++;
                $display("FAIL latency edge t+%0d: out_valid=%b want %b", k, bus.out_valid, (k == W));
            end
        end
        checks++;
        if (bus.out_sum !== exp[W-1:0] || bus.out_cout !== exp[W] || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency result: sum=%h cout=%b rdy=%b want sum=%h cout=%b rdy=0",
                     bus.out_sum, bus.out_cout, bus.in_ready, exp[W-1:0], exp[W]);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency release: rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_carry;
        logic [W-1:0] av [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
        logic [W-1:0] bv [4] = '{8'h01, 8'hFF, 8'h00, 8'h80};
        logic         cv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] s;
        logic         co;
        bit           to;
        logic [W:0]   exp;
        for (int i = 0; i < 4; i++) begin
            exp = model(av[i], bv[i], cv[i], 1'b0);
            run_op(av[i], bv[i], cv[i], 1'b0, s, co, to);
            checks++;
            if (to || s !== exp[W-1:0] || co !== exp[W]) begin
                errors++;
                $display("FAIL carry %h+%h+%b: sum=%h cout=%b to=%b want sum=%h cout=%b",
                         av[i], bv[i], cv[i], s, co, to, exp[W-1:0], exp[W]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, s;
        logic         c, co;
        bit           to;
        logic [W:0]   exp;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            exp = model(a, b, c, 1'b0);
            run_op(a, b, c, 1'b0, s, co, to);
            checks++;
            if (to || s !== exp[W-1:0] || co !== exp[W]) begin
                errors++;
                $display("FAIL random %h+%h+%b: sum=%h cout=%b to=%b want sum=%h cout=%b",
                         a, b, c, s, co, to, exp[W-1:0], exp[W]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a, b, s;
        logic         co;
        bit           to;
        logic [W:0]   exp;
        int           k;
        a   = W'($urandom);
        b   = W'($urandom);
        exp = model(a, b, 1'b1, 1'b0);
        drive_op(a, b, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL backpressure wait: out_valid=%b want 1 within 40 cycles", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            drive_op(8'h11, 8'h11, 1'b0, 1'b0);
            bus.in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_sum !== exp[W-1:0] || bus.out_cout !== exp[W]) begin
                errors++;
                $display("FAIL backpressure hold %0d: vld=%b rdy=%b sum=%h cout=%b want 1 0 %h %b",
                         i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_cout,
                         exp[W-1:0], exp[W]);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        exp = model(a, b, 1'b0, 1'b0);
        run_op(a, b, 1'b0, 1'b0, s, co, to);
        checks++;
        if (to || s !== exp[W-1:0] || co !== exp[W]) begin
            errors++;
            $display("FAIL backpressure next %h+%h: sum=%h cout=%b to=%b want sum=%h cout=%b",
                     a, b, s, co, to, exp[W-1:0], exp[W]);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] s;
        logic         co;
        bit           to;
        drive_op(8'hC3, 8'h5E, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_sum !== '0 || bus.out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset mid-run: rdy=%b vld=%b sum=%h cout=%b want 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, s, co, to);
        checks++;
        if (to || s !== 8'h10 || co !== 1'b0) begin
            errors++;
            $display("FAIL reset recovery: sum=%h cout=%b to=%b want sum=10 cout=0", s, co, to);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        logic         cv [4];
        logic [W:0]   exp_q [$];
        logic [W:0]   e;
        int           acc_cyc [$];
        int           idx, nres, cyc;
        bit           accepting;
        for (int i = 0; i < 4; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
            cv[i] = 1'($urandom);
        end
        idx  = 0;
        nres = 0;
        cyc  = 0;
        bus.out_ready = 1'b1;
        drive_op(av[0], bv[0], cv[0], 1'b0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 80 && nres < 4; k++) begin
            if (bus.out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected result sum=%h", bus.out_sum);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_sum !== e[W-1:0] || bus.out_cout !== e[W]) begin
                        errors++;
                        $display("FAIL stream result %0d: sum=%h cout=%b want sum=%h cout=%b",
                                 nres, bus.out_sum, bus.out_cout, e[W-1:0], e[W]);
                    end
                end
                nres++;
            end
            accepting = bus.in_ready && bus.in_valid;
            @(posedge clk); #1;
            cyc++;
            if (accepting) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(model(av[idx], bv[idx], cv[idx], 1'b0));
                idx++;
                if (idx < 4) drive_op(av[idx], bv[idx], cv[idx], 1'b0);
                else         bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (nres != 4 || acc_cyc.size() != 4) begin
            errors++;
            $display("FAIL stream timeout: results=%0d accepts=%0d want 4 4", nres, acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                errors++;
                $display("FAIL stream spacing %0d: interval=%0d want %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], W + 2);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [W-1:0] av [5] = '{8'h10, 8'h00, 8'h02, 8'h00, 8'h00};
        logic [W-1:0] bv [5] = '{8'h01, 8'h01, 8'h03, 8'h00, 8'h00};
        logic         cv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         sv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] s;
        logic         co;
        bit           to;
        logic [W:0]   exp;
        av[4] = W'($urandom);
        bv[4] = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            exp = model(av[i], bv[i], cv[i], sv[i]);
            run_op(av[i], bv[i], cv[i], sv[i], s, co, to);
            checks++;
            if (to || s !== exp[W-1:0] || co !== exp[W]) begin
                errors++;
                $display("FAIL sub=%b %h,%h cin=%b: sum=%h cout=%b to=%b want sum=%h cout=%b",
                         sv[i], av[i], bv[i], cv[i], s, co, to, exp[W-1:0], exp[W]);
            end
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_op('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_latency();
        test_carry();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
